neuron_mac_seq: RTL and testbench

//  Sequential weighted-sum stage: accepts N binary inputs, N signed weights and a bias.

---
 rtl/neuron_mac_seq.sv | 172 +++++++++++++++++
 tb/tb_neuron_mac_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq
// Sequential weighted-sum stage feeding the sigmoid block. It accepts one
// operand set (binary inputs, signed weights, signed bias) and adds one
// gated weight per clock. It then adds the bias and saturates the total to
// OUT_WIDTH. The result is held on h behind a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set present on x / w_flat / bias
//   in_ready   out  block can accept an operand set (IDLE only)
//   x          in   [N_INPUTS]           binary inputs, x[i] gates weight i
//   w_flat     in   [N_INPUTS*W_WIDTH]   signed weights, lane i at i*W_WIDTH
//   bias       in   [W_WIDTH]            signed bias
//   out_valid  out  h holds a finished result (DONE only)
//   out_ready  in   consumer takes h
//   h          out  [OUT_WIDTH]          signed saturated weighted sum + bias
//   busy       out  high while accumulating or adding the bias
// -----------------------------------------------------------------------------
module neuron_mac_seq #(
    parameter int N_INPUTS  = 4,
    parameter int W_WIDTH   = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_INPUTS-1:0]           x,
    input  logic [N_INPUTS*W_WIDTH-1:0]   w_flat,
    input  logic [W_WIDTH-1:0]            bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          h,
    output logic                          busy
);

    // The accumulator has two guard bits beyond the worst-case sum of N
    // weights, so adding one weight per cycle can never wrap.
    localparam int ACC_W = W_WIDTH + $clog2(N_INPUTS) + 2;
    // The bias addition and clamp use a width that holds both the
    // accumulator and the output range, plus one bit so that the compare
    // against the clamp limits is exact.
    localparam int SUM_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        BIAS = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                        state_reg, state_next;
    logic signed [ACC_W-1:0]       acc_reg;
    logic [IDX_W-1:0]              idx_reg;
    logic [OUT_WIDTH-1:0]          h_reg;

    // Operand copies are taken only at the accept edge. They need no reset
    // because nothing reads them until a new set has been captured.
    logic [N_INPUTS-1:0]           x_reg;
    logic [N_INPUTS*W_WIDTH-1:0]   w_reg;
    logic [W_WIDTH-1:0]            bias_reg;

    logic signed [ACC_W-1:0]       w_ext [N_INPUTS];
    logic signed [ACC_W-1:0]       term;
    logic signed [SUM_W-1:0]       sum;
    logic [OUT_WIDTH-1:0]          h_sat;

    // Sign-extend each captured weight lane to the accumulator width.
    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
            assign w_ext[gi] = {{(ACC_W-W_WIDTH){w_reg[gi*W_WIDTH+W_WIDTH-1]}},
                                w_reg[gi*W_WIDTH +: W_WIDTH]};
        end
    endgenerate

    // Select the weight for the current index. It contributes only when the
    // matching input bit is set.
    always_comb begin
        term = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_reg == IDX_W'(i) && x_reg[i]) begin
                term = w_ext[i];
            end
        end
    end

    always_comb begin
        sum = {{(SUM_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg}
            + {{(SUM_W-W_WIDTH){bias_reg[W_WIDTH-1]}}, bias_reg};
        if (sum > SAT_MAX) begin
            h_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            h_sat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            h_sat = sum[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ACC;
            end
            ACC: begin
                busy = 1'b1;
                if (idx_reg == IDX_LAST) state_next = BIAS;
            end
            BIAS: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            idx_reg   <= '0;
            h_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                ACC: begin
                    acc_reg <= acc_reg + term;
                    idx_reg <= idx_reg + IDX_W'(1);
                end
                // h changes only here, so it holds its last value until the
                // next result is ready.
                BIAS:    h_reg <= h_sat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            x_reg    <= x;
            w_reg    <= w_flat;
            bias_reg <= bias;
        end
    end

    assign h = h_reg;

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

    localparam int NA = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: N=4, OUT_WIDTH=16
    logic        a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic        a_in_ready, a_out_valid, a_busy;
    logic [3:0]  a_x = '0;
    logic [31:0] a_w = '0;
    logic [7:0]  a_bias = '0;
    logic [15:0] a_h;

    // DUT B: N=2, OUT_WIDTH=8 (saturation and latency corner cases)
    logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [1:0]  b_x = '0;
    logic [15:0] b_w = '0;
    logic [7:0]  b_bias = '0;
    logic [7:0]  b_h;

    neuron_mac_seq #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .w_flat(a_w), .bias(a_bias), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .h(a_h), .busy(a_busy)
    );

    neuron_mac_seq #(.N_INPUTS(2), .W_WIDTH(8), .OUT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .w_flat(b_w), .bias(b_bias), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .h(b_h), .busy(b_busy)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event within the cycle budget, required one (cycle %0d)", nm, cyc);
    endtask

    // Reference: plain weighted sum of the gated signed weights plus the bias,
    // clamped to the signed 16-bit range.
    function automatic int ref_h(input logic [3:0] xv, input logic [31:0] wv,
                                 input logic [7:0] bv);
        int s;
        s = int'($signed(bv));
        for (int i = 0; i < NA; i++)
            if (xv[i]) s += int'($signed(wv[i*8 +: 8]));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    // Behavioural model of DUT A. A transaction accepted in cycle T becomes
    // visible in cycle T+N+2. No new set is accepted while one is in flight.
    // h shows the pending result while valid and the last delivered result
    // otherwise.
    bit pending = 0;
    int ready_at = 0;
    int exp_val = 0;
    int last_h = 0;
    bit ov_prev = 0;
    int ov_cyc[$];
    int ov_h[$];

    always @(negedge clk) begin
        bit exp_ov;
        if (rst) begin
            pending = 0;
            last_h  = 0;
            chk("rst_in_ready", a_in_ready, 1);
            chk("rst_out_valid", a_out_valid, 0);
            chk("rst_busy", a_busy, 0);
            chk("rst_h", $signed(a_h), 0);
        end else begin
            exp_ov = pending && (cyc >= ready_at);
            chk("in_ready", a_in_ready, !pending);
            chk("out_valid", a_out_valid, exp_ov);
            chk("busy", a_busy, pending && !exp_ov);
            chk("h", $signed(a_h), exp_ov ? exp_val : last_h);
            if (a_out_valid && !ov_prev) begin
                ov_cyc.push_back(cyc);
                ov_h.push_back(int'($signed(a_h)));
            end
            if (!pending && a_in_valid) begin
                pending  = 1;
                ready_at = cyc + NA + 2;
                exp_val  = ref_h(a_x, a_w, a_bias);
            end else if (exp_ov && a_out_ready) begin
                pending = 0;
                last_h  = exp_val;
            end
        end
        ov_prev = a_out_valid;
    end

    // Present an operand set and hold it until accepted. Afterwards the inputs
    // are scrambled to show that the result in flight ignores them.
    task automatic a_send(input logic [3:0] xv, input logic [31:0] wv, input logic [7:0] bv);
        bit ok = 0;
        a_x = xv; a_w = wv; a_bias = bv; a_in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (a_in_ready) begin ok = 1; break; end
        end
        if (!ok) tmo("a_accept");
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_x = 4'($urandom); a_w = $urandom; a_bias = 8'($urandom);
    endtask

    // Wait for the result, optionally pin it to a literal, and let it be taken.
    task automatic a_recv(input string nm, input bit lit, input int exp, input bit rnd_ready);
        bit ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (a_out_valid && lit && t < 1000) begin
                chk(nm, $signed(a_h), exp);
                lit = 0;
            end
            if (a_out_valid && a_out_ready) begin ok = 1; break; end
            @(posedge clk); #1;
            if (rnd_ready) a_out_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) tmo(nm);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
    endtask

    task automatic b_run(input string nm, input logic [1:0] xv, input logic [15:0] wv,
                         input logic [7:0] bv, input int exp);
        bit ok = 0;
        int t0 = 0;
        b_x = xv; b_w = wv; b_bias = bv; b_in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (b_in_ready) begin ok = 1; t0 = cyc; break; end
        end
        if (!ok) tmo({nm, "_accept"});
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_x = '0; b_w = '0; b_bias = '0;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (b_out_valid) begin ok = 1; break; end
        end
        if (!ok) tmo(nm);
        else begin
            chk({nm, "_latency"}, cyc - t0, 4);
            chk(nm, $signed(b_h), exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        repeat (2) @(negedge clk);
        chk("b_rst_in_ready", b_in_ready, 1);
        chk("b_rst_out_valid", b_out_valid, 0);
        chk("b_rst_h", $signed(b_h), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // AND configuration and saturation on the narrow instance
        b_run("and_00", 2'b00, {8'd20, 8'd20}, 8'hE2, -30);
        b_run("and_01", 2'b01, {8'd20, 8'd20}, 8'hE2, -10);
        b_run("and_10", 2'b10, {8'd20, 8'd20}, 8'hE2, -10);
        b_run("and_11", 2'b11, {8'd20, 8'd20}, 8'hE2, 10);
        b_run("sat_pos", 2'b11, {8'd127, 8'd127}, 8'd127, 127);
        b_run("sat_neg", 2'b11, {8'h80, 8'h80}, 8'h80, -128);

        // Back-to-back with out_ready held high: w[3..0] = 1,2,3,4
        ov_cyc.delete(); ov_h.delete();
        a_send(4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd0);
        a_send(4'b1010, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd0);
        a_recv("b2b_drain", 0, 0, 0);
        if (ov_cyc.size() == 2) begin
            chk("b2b_first", ov_h[0], 10);
            chk("b2b_second", ov_h[1], 4);
            chk("b2b_spacing", ov_cyc[1] - ov_cyc[0], 7);
        end else begin
            chk("b2b_count", ov_cyc.size(), 2);
        end

        // Zero inputs and zero weights
        a_send(4'b0000, $urandom, 8'hFB);
        a_recv("zero_x", 1, -5, 0);
        a_send(4'b1111, 32'd0, 8'd0);
        a_recv("zero_w", 1, 0, 0);

        // Backpressure: hold out_ready low while the inputs keep changing
        a_out_ready = 1'b0;
        a_send(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd5);
        h0 = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (a_out_valid) begin h0 = 1; break; end
        end
        if (h0 == 0) tmo("bp_valid");
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1; a_x = 4'($urandom); a_w = $urandom; a_bias = 8'($urandom);
            @(negedge clk);
            chk("bp_h", $signed(a_h), 105);
            chk("bp_out_valid", a_out_valid, 1);
            chk("bp_in_ready", a_in_ready, 0);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", a_out_valid, 1);
        @(negedge clk);
        chk("bp_release_in_ready", a_in_ready, 1);

        // Reset during the second accumulate cycle, then a clean transaction
        a_send(4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", a_in_ready, 1);
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_h", $signed(a_h), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_send(4'b0110, {8'd1, 8'd2, 8'd3, 8'd4}, 8'hFF);
        a_recv("post_rst", 1, 4, 0);

        // Randomized operand sets with random consumer backpressure
        for (int n = 0; n < 40; n++) begin
            a_send(4'($urandom), $urandom, 8'($urandom));
            a_recv("rand", 0, 0, 1);
            $display("txn %0d done at cycle %0d, h=%0d", n, cyc, $signed(a_h));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
